// File: rtl/drive_ctrl_pkg.sv
// Shared definitions for the drive-circuit instruction sequencer:
// instruction field layout, opcodes and controller states.
package drive_ctrl_pkg;

  localparam int PC_WIDTH   = 11;
  localparam int CNT_WIDTH  = 10;
  localparam int INST_WIDTH = 3 + CNT_WIDTH + PC_WIDTH;
  localparam int OPC_MSB    = INST_WIDTH - 1;
  localparam int CNT_LSB    = PC_WIDTH;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PLAY = 3'd1;
  localparam logic [2:0] OP_WAIT = 3'd2;
  localparam logic [2:0] OP_JUMP = 3'd3;
  localparam logic [2:0] OP_LOOP = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADV   = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/drive_dwell_cnt.sv
// Dwell counter shared by PLAY and WAIT: load, decrement toward zero,
// and report when the count has reached zero.
module drive_dwell_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/drive_seq_ctrl.sv
// Drive-circuit instruction sequencer: fetches and decodes instructions,
// steers the PC register and gates pulse playback.
module drive_seq_ctrl
  import drive_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic                  update_pc_o,
  output logic [PC_WIDTH-1:0]   next_pc_o,
  output logic                  busy_o,
  output logic                  play_en_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  next_pc_q, next_pc_d;
  logic                 update_pc_q, busy_q, play_en_q, done_q;
  logic                 err_q, err_d;
  logic                 loop_act_q, loop_act_d;
  logic [CNT_WIDTH-1:0] loop_rem_q, loop_rem_d;
  logic                 play_d;
  logic                 dwell_load_s, dwell_dec_s, dwell_zero_s;

  logic [2:0]           opcode_s;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic [PC_WIDTH-1:0]  target_s;
  logic [PC_WIDTH-1:0]  pc_inc_s;

  assign opcode_s = inst_i[OPC_MSB -: 3];
  assign cnt_s    = inst_i[CNT_LSB +: CNT_WIDTH];
  assign target_s = inst_i[PC_WIDTH-1:0];
  assign pc_inc_s = pc_i + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  drive_dwell_cnt #(.W(CNT_WIDTH)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dwell_load_s),
    .dec_i      (dwell_dec_s),
    .load_val_i (cnt_s),
    .zero_o     (dwell_zero_s)
  );

  // Next-state and decode logic; stop overrides everything.
  always_comb begin
    state_d      = state_q;
    next_pc_d    = next_pc_q;
    err_d        = err_q;
    loop_act_d   = loop_act_q;
    loop_rem_d   = loop_rem_q;
    play_d       = play_en_q;
    dwell_load_s = 1'b0;
    dwell_dec_s  = 1'b0;
    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d    = S_ADV;
            next_pc_d  = {PC_WIDTH{1'b0}};
            err_d      = 1'b0;
            loop_act_d = 1'b0;
            loop_rem_d = {CNT_WIDTH{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADV:   state_d = S_FETCH;
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          case (opcode_s)
            OP_NOP: begin
              next_pc_d = pc_inc_s;
              state_d   = S_ADV;
            end
            OP_PLAY, OP_WAIT: begin
              dwell_load_s = 1'b1;
              play_d       = (opcode_s == OP_PLAY);
              state_d      = S_HOLD;
            end
            OP_JUMP: begin
              next_pc_d = target_s;
              state_d   = S_ADV;
            end
            OP_LOOP: begin
              state_d = S_ADV;
              if (!loop_act_q && (cnt_s == {CNT_WIDTH{1'b0}})) begin
                next_pc_d = pc_inc_s;
              end else if (!loop_act_q) begin
                loop_act_d = 1'b1;
                loop_rem_d = cnt_s - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                next_pc_d  = target_s;
              end else if (loop_rem_q == {CNT_WIDTH{1'b0}}) begin
                loop_act_d = 1'b0;
                next_pc_d  = pc_inc_s;
              end else begin
                loop_rem_d = loop_rem_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                next_pc_d  = target_s;
              end
            end
            OP_HALT: state_d = S_DONE;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
        S_HOLD: begin
          if (dwell_zero_s) begin
            next_pc_d = pc_inc_s;
            state_d   = S_ADV;
          end else begin
            dwell_dec_s = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered Moore outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      next_pc_q   <= {PC_WIDTH{1'b0}};
      update_pc_q <= 1'b0;
      busy_q      <= 1'b0;
      play_en_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      loop_act_q  <= 1'b0;
      loop_rem_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      next_pc_q   <= next_pc_d;
      update_pc_q <= (state_d == S_ADV);
      busy_q      <= (state_d != S_IDLE);
      play_en_q   <= (state_d == S_HOLD) && play_d;
      done_q      <= (state_d == S_DONE);
      err_q       <= err_d;
      loop_act_q  <= loop_act_d;
      loop_rem_q  <= loop_rem_d;
    end
  end

  assign update_pc_o = update_pc_q;
  assign next_pc_o   = next_pc_q;
  assign busy_o      = busy_q;
  assign play_en_o   = play_en_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_drive_seq_ctrl.sv
// Bench for drive_seq_ctrl with a priming-aware PC register and a
// 1-cycle synchronous instruction memory.
module tb_drive_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [10:0] pc;
  logic [23:0] inst;
  logic        update_pc, busy, play_en, done, err;
  logic [10:0] next_pc;
  logic        primed;
  logic [23:0] mem [2048];

  int checks = 0;
  int errors = 0;
  int upd_log[$];
  int play_cnt, play_max, cur_run, done_cnt;

  always #5 clk = ~clk;

  drive_seq_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .pc_i(pc), .inst_i(inst),
    .update_pc_o(update_pc), .next_pc_o(next_pc), .busy_o(busy),
    .play_en_o(play_en), .done_o(done), .err_o(err)
  );

  // PC register: the first update after reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= 11'd0;
      primed <= 1'b0;
    end else if (update_pc) begin
      if (primed) pc <= next_pc;
      primed <= 1'b1;
    end
  end

  always_ff @(posedge clk) inst <= mem[pc];

  function automatic logic [23:0] enc(input int op, input int cnt, input int tgt);
    logic [2:0]  o;
    logic [9:0]  c;
    logic [10:0] t;
    o = op[2:0]; c = cnt[9:0]; t = tgt[10:0];
    return {o, c, t};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    upd_log.delete();
    play_cnt = 0; play_max = 0; cur_run = 0; done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (update_pc) upd_log.push_back(int'(next_pc));
    if (play_en) begin
      play_cnt++;
      cur_run++;
      if (cur_run > play_max) play_max = cur_run;
    end else begin
      cur_run = 0;
    end
    if (done) done_cnt++;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 2048; i++) mem[i] = enc(5, 0, 0);
  endtask

  task automatic run_prog(input int max_cycles);
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < max_cycles && done_cnt == 0; i++) step();
    step();
    chk("run_done_seen", done_cnt, 1);
    chk("run_idle_after", int'(busy), 0);
  endtask

  typedef struct {
    logic        start;
    logic        upd;
    logic [10:0] npc;
    logic        busy;
    logic        done;
    logic [10:0] pc;
  } vec_t;

  vec_t tv[8];

  initial begin
    // cycle-by-cycle expectations for the [NOP, HALT] program; start in
    // vector 2 arrives while busy and must be ignored
    tv[0] = '{1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 11'd0};
    tv[1] = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'd0};
    tv[2] = '{1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 11'd0};
    tv[3] = '{1'b0, 1'b1, 11'd1, 1'b1, 1'b0, 11'd0};
    tv[4] = '{1'b0, 1'b0, 11'd1, 1'b1, 1'b0, 11'd1};
    tv[5] = '{1'b0, 1'b0, 11'd1, 1'b1, 1'b0, 11'd1};
    tv[6] = '{1'b0, 1'b0, 11'd1, 1'b1, 1'b1, 11'd1};
    tv[7] = '{1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 11'd1};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    fill_halt();
    clear_log();
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_update_pc", int'(update_pc), 0);
    chk("rst_next_pc", int'(next_pc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_play_en", int'(play_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);

    // NOP, HALT
    mem[0] = enc(0, 0, 0);
    mem[1] = enc(5, 0, 0);
    for (int i = 0; i < 8; i++) begin
      start = tv[i].start;
      step();
      chk($sformatf("tv%0d_update_pc", i), int'(update_pc), int'(tv[i].upd));
      chk($sformatf("tv%0d_next_pc", i), int'(next_pc), int'(tv[i].npc));
      chk($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].busy));
      chk($sformatf("tv%0d_done", i), int'(done), int'(tv[i].done));
      chk($sformatf("tv%0d_pc", i), int'(pc), int'(tv[i].pc));
      chk($sformatf("tv%0d_play_en", i), int'(play_en), 0);
      chk($sformatf("tv%0d_err", i), int'(err), 0);
    end
    start = 1'b0;

    // PLAY cnt=4 then HALT
    fill_halt();
    mem[0] = enc(1, 4, 0);
    run_prog(200);
    chk("play_total", play_cnt, 5);
    chk("play_consecutive", play_max, 5);
    chk("play_final_pc", int'(pc), 1);

    // NOP, LOOP cnt=2 -> 0, HALT
    fill_halt();
    mem[0] = enc(0, 0, 0);
    mem[1] = enc(4, 2, 0);
    run_prog(200);
    chk("loop_log_len", upd_log.size(), 7);
    if (upd_log.size() == 7) begin
      int exp_l[7];
      exp_l = '{0, 1, 0, 1, 0, 1, 2};
      for (int i = 0; i < 7; i++) chk($sformatf("loop_pc%0d", i), upd_log[i], exp_l[i]);
    end
    chk("loop_act_end", int'(dut.loop_act_q), 0);

    // LOOP cnt=1 jumping to 2047, NOP at 2047 wraps to 0, then HALT at 1
    fill_halt();
    mem[0]    = enc(4, 1, 2047);
    mem[2047] = enc(0, 0, 0);
    run_prog(200);
    chk("wrap_log_len", upd_log.size(), 4);
    if (upd_log.size() == 4) begin
      chk("wrap_pc1", upd_log[1], 2047);
      chk("wrap_pc2", upd_log[2], 0);
      chk("wrap_pc3", upd_log[3], 1);
    end

    // stop in the 3rd HOLD cycle of WAIT cnt=9
    fill_halt();
    mem[0] = enc(2, 9, 0);
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("stop_busy_before", int'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_play_en", int'(play_en), 0);
    chk("wait_no_play", play_cnt, 0);
    clear_log();
    for (int i = 0; i < 10; i++) step();
    chk("stop_no_update", upd_log.size(), 0);
    run_prog(200);
    chk("restart_first_pc", (upd_log.size() > 0) ? upd_log[0] : -1, 0);
    chk("restart_final_pc", int'(pc), 1);

    // illegal opcode 7
    fill_halt();
    mem[0] = enc(7, 0, 0);
    run_prog(200);
    chk("illegal_err", int'(err), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_clears_err", int'(err), 0);
    chk("restart_update_pc", int'(update_pc), 1);
    clear_log();
    for (int i = 0; i < 50 && done_cnt == 0; i++) step();
    chk("illegal_again_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
